mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester round-robin arbiter in front of the single-port synchronous-read memory (8-bit words, 256 entries, one write enable per byte).
- Port A is the UART command controller; port B is a secondary engine (e.g. memory dump/fill sequencer).
- One memory access at a time; per-port req/ack handshake; read data is returned with a valid strobe.

Parameters:
- MEM_WIDTH, 8, data width of a memory word.
- MEM_DEPTH, 256, number of memory entries.
- MEM_ADDR_WIDTH, $clog2(MEM_DEPTH), address width.
- NUM_BYTES_PER_WORD, MEM_WIDTH/8, width of the byte write-enable.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_req  in  1  port A request; held high until a_ack.
- a_we  in  NUM_BYTES_PER_WORD  port A byte write enables; 0 means read.
- a_addr  in  MEM_ADDR_WIDTH  port A address.
- a_wdata  in  MEM_WIDTH  port A write data.
- a_ack  out  1  one-cycle pulse; port A transaction complete.
- a_rdata  out  MEM_WIDTH  port A read data; valid when a_rvalid is high.
- a_rvalid  out  1  one-cycle pulse; coincides with a_ack on reads.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata, b_rvalid: same as port A, for port B.
- mem_we  out  NUM_BYTES_PER_WORD  memory byte write enables.
- mem_addr  out  MEM_ADDR_WIDTH  memory address.
- mem_din  out  MEM_WIDTH  memory write data.
- mem_dout  in  MEM_WIDTH  memory read data; valid one cycle after the address is presented.
- arb_state  out  2  current FSM state, for LEDs.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE; owner = A; last_grant = B, so A wins the first tie.
  - a_ack, b_ack, a_rvalid, b_rvalid, mem_we = 0.
  - a_rdata, b_rdata, mem_addr, mem_din = 0.
  - Reset asserted mid-transaction aborts it: no ack, and no write if reset is asserted in the ISSUE cycle.
- States (arb_state encoding): IDLE=0, ISSUE=1, READ_RSP=2.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If only one port requests, register it as owner and go to ISSUE.
  - If both request, the port not equal to last_grant wins; update last_grant to the winner; go to ISSUE.
- ISSUE:
  - mem_addr and mem_din are driven combinationally from the owner's addr and wdata.
  - mem_we = owner's we.
  - If we != 0 (write): assert owner's ack this cycle; go to IDLE.
  - If we == 0 (read): mem_we = 0; go to READ_RSP.
- READ_RSP:
  - Owner's rdata is registered from mem_dout; owner's ack and rvalid are asserted one cycle after the read address was presented.
  - Go to IDLE.
- Latency, counted from the cycle req is first sampled high in IDLE (cycle 0):
  - Write: ack and mem_we in cycle 1.
  - Read: ack and rvalid in cycle 2.
  - Minimum spacing between grants: write every 2 cycles, read every 3 cycles.
- Outside ISSUE, mem_we = 0. mem_addr and mem_din hold the owner's values (don't-care to memory).
- The non-owner's ack and rvalid stay 0.
- rdata holds its last value until the next read by that port.
- A requester must hold req, we, addr and wdata stable until ack.
  - A req dropped early is a protocol violation. The arbiter still completes the granted transaction using the current port values.
- A req reasserted in the cycle after ack is treated as a new request. Under contention, priority rotates so the other port is served next.
- Address wrap: none. Addresses map directly; all MEM_DEPTH entries are reachable.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined:
  - Adds outputs a_grant_cnt [15:0] and b_grant_cnt [15:0], plus input stats_clr.
  - Each counter increments on its port's ack and saturates at 16'hFFFF.
  - stats_clr clears both counters synchronously; stats_clr has priority over an increment in the same cycle.
  - Both counters reset to 0 on rst_n.
- When undefined: the ports and counters are absent; arbitration is unchanged.

Test Plan:
- Reset: drive rst_n low asynchronously mid-ISSUE on a write a_we=1, a_addr=8'h10 -> no mem_we pulse, all outputs 0, arb_state=0.
- Single-port write then read: A writes 8'hA5 to 8'h20 -> a_ack and mem_we=1 in cycle 1. A reads 8'h20 -> a_ack and a_rvalid in cycle 2 with a_rdata=8'hA5.
- Contention: a_req and b_req both high from reset with reads of 8'h00 and 8'h01 -> A served first, then B. Keep both asserted -> grants alternate A,B,A,B.
- Cross-port coherence: B writes 8'h3C to 8'hFF, then A reads 8'hFF -> a_rdata=8'h3C. b_ack never pulses during A's transaction.
- Back-to-back same port: A issues 4 consecutive writes (addresses 0..3) with B idle -> acks at cycles 1, 3, 5, 7.
- MEM_ARB_STATS_EN: 3 A grants and 2 B grants -> a_grant_cnt=3, b_grant_cnt=2. Pulse stats_clr coincident with an ack -> both counters read 0 the next cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single-port,
// synchronous-read memory (one access at a time).
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   a_req/a_we/a_addr/a_wdata  port A request (UART command controller)
//   a_ack/a_rdata/a_rvalid     port A completion and read data
//   b_*                        same for port B (secondary engine)
//   mem_we/mem_addr/mem_din    memory command
//   mem_dout                   memory read data, one cycle after address
//   arb_state                  FSM state for LEDs (IDLE=0, ISSUE=1, READ_RSP=2)
//
// Optional build macro MEM_ARB_STATS_EN adds stats_clr, a_grant_cnt and
// b_grant_cnt: saturating 16-bit per-port ack counters.
module mem_arbiter #(
  parameter int MEM_WIDTH          = 8,
  parameter int MEM_DEPTH          = 256,
  parameter int MEM_ADDR_WIDTH     = $clog2(MEM_DEPTH),
  parameter int NUM_BYTES_PER_WORD = MEM_WIDTH / 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          a_req,
  input  logic [NUM_BYTES_PER_WORD-1:0] a_we,
  input  logic [MEM_ADDR_WIDTH-1:0]     a_addr,
  input  logic [MEM_WIDTH-1:0]          a_wdata,
  output logic                          a_ack,
  output logic [MEM_WIDTH-1:0]          a_rdata,
  output logic                          a_rvalid,
  input  logic                          b_req,
  input  logic [NUM_BYTES_PER_WORD-1:0] b_we,
  input  logic [MEM_ADDR_WIDTH-1:0]     b_addr,
  input  logic [MEM_WIDTH-1:0]          b_wdata,
  output logic                          b_ack,
  output logic [MEM_WIDTH-1:0]          b_rdata,
  output logic                          b_rvalid,
  output logic [NUM_BYTES_PER_WORD-1:0] mem_we,
  output logic [MEM_ADDR_WIDTH-1:0]     mem_addr,
  output logic [MEM_WIDTH-1:0]          mem_din,
  input  logic [MEM_WIDTH-1:0]          mem_dout,
`ifdef MEM_ARB_STATS_EN
  input  logic                          stats_clr,
  output logic [15:0]                   a_grant_cnt,
  output logic [15:0]                   b_grant_cnt,
`endif
  output logic [1:0]                    arb_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    READ_RSP = 2'd2
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  state_t state, state_nxt;
  logic   owner, owner_nxt;
  logic   last_grant, last_grant_nxt;

  logic [NUM_BYTES_PER_WORD-1:0] own_we;
  logic [MEM_ADDR_WIDTH-1:0]     own_addr;
  logic [MEM_WIDTH-1:0]          own_wdata;
  logic                          wr_done, rd_done;
  logic [MEM_WIDTH-1:0]          a_rdata_q, b_rdata_q;

  assign own_we    = (owner == PORT_B) ? b_we    : a_we;
  assign own_addr  = (owner == PORT_B) ? b_addr  : a_addr;
  assign own_wdata = (owner == PORT_B) ? b_wdata : a_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= PORT_A;
      last_grant <= PORT_B;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (a_req && b_req) begin
          // rotate only on contention: loser of the previous tie wins now
          owner_nxt      = (last_grant == PORT_A) ? PORT_B : PORT_A;
          last_grant_nxt = owner_nxt;
          state_nxt      = ISSUE;
        end else if (a_req) begin
          owner_nxt = PORT_A;
          state_nxt = ISSUE;
        end else if (b_req) begin
          owner_nxt = PORT_B;
          state_nxt = ISSUE;
        end
      end
      ISSUE:    state_nxt = (own_we != '0) ? IDLE : READ_RSP;
      READ_RSP: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Writes complete in ISSUE (memory commits at the closing edge); reads
  // complete in READ_RSP once mem_dout carries the addressed word.
  assign wr_done = (state == ISSUE) && (own_we != '0);
  assign rd_done = (state == READ_RSP);

  assign mem_we   = (state == ISSUE) ? own_we : '0;
  // Address/data follow the owner at all times; forced to 0 while in reset.
  assign mem_addr = rst_n ? own_addr  : '0;
  assign mem_din  = rst_n ? own_wdata : '0;

  assign a_ack    = (owner == PORT_A) && (wr_done || rd_done);
  assign b_ack    = (owner == PORT_B) && (wr_done || rd_done);
  assign a_rvalid = (owner == PORT_A) && rd_done;
  assign b_rvalid = (owner == PORT_B) && rd_done;

  // rdata register captures mem_dout at the end of READ_RSP; during the
  // rvalid cycle itself mem_dout is forwarded so data and strobe coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_rvalid) a_rdata_q <= mem_dout;
      if (b_rvalid) b_rdata_q <= mem_dout;
    end
  end

  assign a_rdata   = a_rvalid ? mem_dout : a_rdata_q;
  assign b_rdata   = b_rvalid ? mem_dout : b_rdata_q;
  assign arb_state = state;

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_grant_cnt <= '0;
      b_grant_cnt <= '0;
    end else if (stats_clr) begin
      a_grant_cnt <= '0;
      b_grant_cnt <= '0;
    end else begin
      if (a_ack && a_grant_cnt != 16'hFFFF) a_grant_cnt <= a_grant_cnt + 16'd1;
      if (b_ack && b_grant_cnt != 16'hFFFF) b_grant_cnt <= b_grant_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. A behavioural memory
// supplies mem_dout; ref_mem tracks expected contents at transaction level.
module tb_mem_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       a_req = 1'b0, b_req = 1'b0;
  logic [0:0] a_we = '0, b_we = '0;
  logic [7:0] a_addr = '0, b_addr = '0, a_wdata = '0, b_wdata = '0;
  logic       a_ack, b_ack, a_rvalid, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic [0:0] mem_we;
  logic [7:0] mem_addr, mem_din, mem_dout;
  logic [1:0] arb_state;
`ifdef MEM_ARB_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] a_grant_cnt, b_grant_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] sim_mem [0:255] = '{default: 8'h00};
  logic [7:0] ref_mem [0:255] = '{default: 8'h00};

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
`ifdef MEM_ARB_STATS_EN
    .stats_clr(stats_clr), .a_grant_cnt(a_grant_cnt), .b_grant_cnt(b_grant_cnt),
`endif
    .arb_state(arb_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous-read, write-through-next-cycle memory
  always @(posedge clk) begin
    if (mem_we[0]) sim_mem[mem_addr] <= mem_din;
    mem_dout <= sim_mem[mem_addr];
  end

  // every cycle: never two acks, and memory is written only by a write ack
  always @(negedge clk) begin
    logic [0:0] exp_we;
    exp_we = (a_ack === 1'b1 && a_we != 0) ? a_we :
             (b_ack === 1'b1 && b_we != 0) ? b_we : 1'b0;
    checks++;
    if (a_ack === 1'b1 && b_ack === 1'b1) begin
      errors++; $display("FAIL dual_ack a_ack=%b b_ack=%b required at most one", a_ack, b_ack);
    end
    checks++;
    if (mem_we !== exp_we) begin
      errors++; $display("FAIL mem_we_consistency got=%b required=%b", mem_we, exp_we);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic set_port(input bit p, input logic req, input logic we,
                          input logic [7:0] addr, input logic [7:0] wd);
    if (!p) begin a_req = req; a_we = we; a_addr = addr; a_wdata = wd; end
    else    begin b_req = req; b_we = we; b_addr = addr; b_wdata = wd; end
  endtask

  // One transaction; starts and returns at posedge+1. lat counts cycles from
  // the first cycle req is visible (cycle 0) to the ack cycle, -1 on timeout.
  task automatic txn(input bit p, input logic we, input logic [7:0] addr,
                     input logic [7:0] wd, input bit hold, input int max_lat,
                     output int lat);
    logic ack, rv;
    logic [7:0] rd;
    set_port(p, 1'b1, we, addr, wd);
    lat = -1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      ack = p ? b_ack : a_ack;
      if (ack === 1'b1) begin lat = c; break; end
    end
    checks++;
    if (lat < 0 || lat > max_lat) begin
      errors++;
      $display("FAIL latency port=%s addr=%h got=%0d required<=%0d", p ? "B" : "A", addr, lat, max_lat);
    end
    if (lat >= 0) begin
      rv = p ? b_rvalid : a_rvalid;
      rd = p ? b_rdata : a_rdata;
      checks++;
      if (rv !== ~we) begin
        errors++; $display("FAIL rvalid port=%s got=%b required=%b", p ? "B" : "A", rv, ~we);
      end
      checks++;
      if (we) begin
        if (mem_addr !== addr || mem_din !== wd) begin
          errors++;
          $display("FAIL mem_cmd port=%s got=%h/%h required=%h/%h", p ? "B" : "A", mem_addr, mem_din, addr, wd);
        end
        ref_mem[addr] = wd;
      end else if (rd !== ref_mem[addr]) begin
        errors++;
        $display("FAIL rdata port=%s addr=%h got=%h required=%h", p ? "B" : "A", addr, rd, ref_mem[addr]);
      end
    end
    @(posedge clk); #1;
    if (!hold) set_port(p, 1'b0, we, addr, wd);
  endtask

  task automatic apply_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_port(0, 1'b1, 1'b1, 8'h10, 8'h77);
    @(negedge clk);
    checks++;
    if ({a_ack, b_ack, a_rvalid, b_rvalid, mem_we} !== 5'b0 || arb_state !== 2'd0) begin
      errors++; $display("FAIL reset_ctrl got=%b st=%0d required=0", {a_ack, b_ack, a_rvalid, b_rvalid, mem_we}, arb_state);
    end
    checks++;
    if ({a_rdata, b_rdata, mem_addr, mem_din} !== 32'h0) begin
      errors++; $display("FAIL reset_data got=%h required=0", {a_rdata, b_rdata, mem_addr, mem_din});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (arb_state !== 2'd1 || mem_we !== 1'b1) begin
      errors++; $display("FAIL reset_issue st=%0d we=%b required 1/1", arb_state, mem_we);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || a_ack !== 1'b0 || arb_state !== 2'd0 || mem_addr !== 8'h0) begin
      errors++; $display("FAIL reset_abort we=%b ack=%b st=%0d addr=%h required 0", mem_we, a_ack, arb_state, mem_addr);
    end
    @(posedge clk); #1;
    checks++;
    if (sim_mem[8'h10] !== 8'h00) begin
      errors++; $display("FAIL reset_nowrite mem[10]=%h required=00", sim_mem[8'h10]);
    end
    set_port(0, 1'b0, 1'b0, 8'h0, 8'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int lat;
    txn(0, 1'b1, 8'h20, 8'hA5, 0, 1, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL wr_latency got=%0d required=1", lat); end
    txn(0, 1'b0, 8'h20, 8'h00, 0, 2, lat);
    checks++;
    if (lat !== 2 || a_rdata !== 8'hA5) begin
      errors++; $display("FAIL rd_latency_data got=%0d/%h required=2/a5", lat, a_rdata);
    end
  endtask

  task automatic test_contention();
    int k;
    bit p;
    apply_reset();
    k = 0;
    set_port(0, 1'b1, 1'b0, 8'h00, 8'h00);
    set_port(1, 1'b1, 1'b0, 8'h01, 8'h00);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (a_ack === 1'b1 || b_ack === 1'b1) begin
        p = (b_ack === 1'b1);
        checks++;
        if (p !== k[0] || c !== 2 + 3 * k) begin
          errors++;
          $display("FAIL contention_order ack#%0d got=%s@%0d required=%s@%0d", k, p ? "B" : "A", c, k[0] ? "B" : "A", 2 + 3 * k);
        end
        checks++;
        if ((p ? b_rdata : a_rdata) !== ref_mem[{7'd0, p}]) begin
          errors++; $display("FAIL contention_rdata got=%h required=%h", p ? b_rdata : a_rdata, ref_mem[{7'd0, p}]);
        end
        k++;
      end
    end
    checks++;
    if (k !== 4) begin errors++; $display("FAIL contention_count got=%0d required=4", k); end
    @(posedge clk); #1;
    set_port(0, 1'b0, 1'b0, 8'h0, 8'h0);
    set_port(1, 1'b0, 1'b0, 8'h0, 8'h0);
  endtask

  task automatic test_coherence();
    int lat;
    txn(1, 1'b1, 8'hFF, 8'h3C, 0, 1, lat);
    fork
      txn(0, 1'b0, 8'hFF, 8'h00, 0, 2, lat);
      repeat (3) begin
        @(negedge clk);
        checks++;
        if (b_ack !== 1'b0) begin errors++; $display("FAIL coh_b_ack got=%b required=0", b_ack); end
      end
    join
    checks++;
    if (a_rdata !== 8'h3C) begin errors++; $display("FAIL coh_rdata got=%h required=3c", a_rdata); end
    txn(1, 1'b0, 8'h20, 8'h00, 0, 2, lat);
    checks++;
    if (a_rdata !== 8'h3C || b_rdata !== 8'hA5) begin
      errors++; $display("FAIL rdata_hold got=%h/%h required=3c/a5", a_rdata, b_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int lat, t0, st;
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      st = cyc;
      txn(0, 1'b1, 8'(i), 8'($urandom), (i < 3), 1, lat);
      checks++;
      if (st - t0 + lat !== 1 + 2 * i) begin
        errors++; $display("FAIL b2b_ack_cycle write%0d got=%0d required=%0d", i, st - t0 + lat, 1 + 2 * i);
      end
    end
  endtask

  task automatic test_random();
    fork
      begin
        int lat_a, g;
        for (int i = 0; i < 25; i++) begin
          g = $urandom_range(0, 3);
          if (g > 0) begin repeat (g) @(posedge clk); #1; end
          txn(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom), 0, 12, lat_a);
        end
      end
      begin
        int lat_b, g;
        for (int i = 0; i < 25; i++) begin
          g = $urandom_range(0, 3);
          if (g > 0) begin repeat (g) @(posedge clk); #1; end
          txn(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom), 0, 12, lat_b);
        end
      end
    join
  endtask

`ifdef MEM_ARB_STATS_EN
  task automatic test_stats();
    int lat;
    stats_clr = 1'b1; @(posedge clk); #1; stats_clr = 1'b0;
    for (int i = 0; i < 3; i++) txn(0, 1'b1, 8'(8'h40 + i), 8'(i), 0, 1, lat);
    for (int i = 0; i < 2; i++) txn(1, 1'b1, 8'(8'h50 + i), 8'(i), 0, 1, lat);
    checks++;
    if (a_grant_cnt !== 16'd3 || b_grant_cnt !== 16'd2) begin
      errors++; $display("FAIL stats_count got=%0d/%0d required=3/2", a_grant_cnt, b_grant_cnt);
    end
    set_port(0, 1'b1, 1'b1, 8'h60, 8'h99);
    @(posedge clk); #1;
    stats_clr = 1'b1;
    @(negedge clk);
    checks++;
    if (a_ack !== 1'b1) begin errors++; $display("FAIL stats_clr_ack got=%b required=1", a_ack); end
    ref_mem[8'h60] = 8'h99;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    set_port(0, 1'b0, 1'b0, 8'h0, 8'h0);
    @(negedge clk);
    checks++;
    if (a_grant_cnt !== 16'd0 || b_grant_cnt !== 16'd0) begin
      errors++; $display("FAIL stats_clr_priority got=%0d/%0d required=0/0", a_grant_cnt, b_grant_cnt);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_contention();
    test_coherence();
    test_back_to_back();
    test_random();
`ifdef MEM_ARB_STATS_EN
    test_stats();
`endif
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
